// File: rtl/avalon_pack.sv
`default_nettype none
// ============================================================================
// Package     : avalon_pack
// Description : Shared types and width helpers for the Avalon-ST packetizer.
// Revision    : 1.0 - initial release
// ============================================================================
package avalon_pack;
   import general_pack::*;

   // Packetizer framing state: IDLE expects an sop word, ACTIVE is mid-packet.
   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   // Width of the packet-length field (must hold 0..max_packet_bytes).
   function automatic int len_w_func(input int max_packet_bytes);
      return log2up_func(max_packet_bytes + 1);
   endfunction

   // Width of the empty field (holds 0..data_width_in_bytes-1).
   function automatic int empty_w_func(input int data_width_in_bytes);
      return log2up_func(data_width_in_bytes);
   endfunction

endpackage
`default_nettype wire

// File: rtl/general_pack.sv
`default_nettype none
// ============================================================================
// Package     : general_pack
// Description : General-purpose sizing helpers shared across blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package general_pack;

   // Bits needed to encode the values 0..value-1, never less than one bit.
   function automatic int log2up_func(input int value);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << r) < value) begin
            r = r + 1;
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/avalon_st_packetizer_if.sv
`default_nettype none
// ============================================================================
// Interface   : avalon_st_packetizer_if
// Description : Raw word input stream plus framed Avalon-ST output stream.
//               master = packetizer view, slave = producer/sink environment.
//               AVALON_PACKETIZER_ABORT_EN adds in_abort / out_error.
// Revision    : 1.0 - initial release
// ============================================================================
interface avalon_st_packetizer_if #(
   parameter int DATA_WIDTH_IN_BYTES = 16
) ();
   localparam int EMPTY_W = avalon_pack::empty_w_func(DATA_WIDTH_IN_BYTES);

   logic [8*DATA_WIDTH_IN_BYTES-1:0] in_data;
   logic                             in_valid;
   logic                             in_ready;
   logic [8*DATA_WIDTH_IN_BYTES-1:0] out_data;
   logic                             out_valid;
   logic                             out_ready;
   logic                             out_startofpacket;
   logic                             out_endofpacket;
   logic [EMPTY_W-1:0]               out_empty;
`ifdef AVALON_PACKETIZER_ABORT_EN
   logic                             in_abort;
   logic                             out_error;

   modport master (
      input  in_data, in_valid, in_abort, out_ready,
      output in_ready, out_data, out_valid, out_startofpacket,
             out_endofpacket, out_empty, out_error
   );

   modport slave (
      output in_data, in_valid, in_abort, out_ready,
      input  in_ready, out_data, out_valid, out_startofpacket,
             out_endofpacket, out_empty, out_error
   );
`else
   modport master (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_startofpacket,
             out_endofpacket, out_empty
   );

   modport slave (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_startofpacket,
             out_endofpacket, out_empty
   );
`endif

endinterface
`default_nettype wire

// File: rtl/avalon_st_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : avalon_st_out_reg
// Description : Single valid/ready output register. Accepts a new payload
//               whenever it is empty or its current word is being taken, and
//               holds the payload stable while stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_st_out_reg #(
   parameter int PAYLOAD_W = 8
) (
   input  wire logic                 clk,
   input  wire logic                 rst,
   input  wire logic                 i_valid,
   output logic                      o_ready,
   input  wire logic [PAYLOAD_W-1:0] i_data,
   output logic                      o_valid,
   output logic [PAYLOAD_W-1:0]      o_data,
   input  wire logic                 i_ready
);

   logic                 r_valid;
   logic [PAYLOAD_W-1:0] r_data;

   // Upstream may push whenever the register is empty or draining this cycle.
   assign o_ready = !r_valid || i_ready;

   // Load on upstream handshake; payload only changes when a word is loaded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (o_ready) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_data <= i_data;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/avalon_st_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : avalon_st_packetizer
// Description : Frames an unframed word stream into Avalon-ST packets of a
//               configurable byte length (sop/eop/empty), one register stage.
//               Optional macro AVALON_PACKETIZER_ABORT_EN adds in_abort, which
//               closes the packet early and flags the word with out_error.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_st_packetizer
   import general_pack::*, avalon_pack::*;
#(
   parameter  int DATA_WIDTH_IN_BYTES = 16,
   parameter  int MAX_PACKET_BYTES    = 1024,
   localparam int LEN_W               = len_w_func(MAX_PACKET_BYTES),
   localparam int EMPTY_W             = empty_w_func(DATA_WIDTH_IN_BYTES)
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic [LEN_W-1:0]  cfg_packet_len,
   avalon_st_packetizer_if.master bus,
   output logic                   busy
);

   localparam int DATA_W = 8 * DATA_WIDTH_IN_BYTES;
   // Counting width wide enough for both a packet length and the word size.
   localparam int DW_W   = log2up_func(DATA_WIDTH_IN_BYTES + 1);
   localparam int CNT_W  = (LEN_W > DW_W) ? LEN_W : DW_W;

   localparam logic [CNT_W-1:0] c_word_bytes = CNT_W'(DATA_WIDTH_IN_BYTES);
   localparam logic [LEN_W-1:0] c_max_len    = LEN_W'(MAX_PACKET_BYTES);

`ifdef AVALON_PACKETIZER_ABORT_EN
   localparam int PAYLOAD_W = 1 + EMPTY_W + 2 + DATA_W;
`else
   localparam int PAYLOAD_W = EMPTY_W + 2 + DATA_W;
`endif

   state_t                r_state;
   logic [LEN_W-1:0]      r_remaining;
   logic                  r_busy;

   logic [LEN_W-1:0]      w_eff_len;
   logic [CNT_W-1:0]      w_count;
   logic                  w_last;
   logic                  w_abort;
   logic                  w_sop;
   logic                  w_eop;
   logic [EMPTY_W-1:0]    w_empty;
   logic                  w_in_ready;
   logic                  w_load;
   logic [PAYLOAD_W-1:0]  w_pay_d;
   logic [PAYLOAD_W-1:0]  w_pay_q;
   logic                  w_q_valid;
   logic                  w_q_eop;

`ifdef AVALON_PACKETIZER_ABORT_EN
   assign w_abort = bus.in_abort;
`else
   assign w_abort = 1'b0;
`endif

   assign w_load = bus.in_valid && w_in_ready;

   // Zero or out-of-range lengths fall back to the largest legal packet.
   always_comb begin
      w_eff_len = cfg_packet_len;
      if ((cfg_packet_len == '0) || (cfg_packet_len > c_max_len)) begin
         w_eff_len = c_max_len;
      end
   end

   // Framing of the word being offered: bytes left in the packet decide eop/empty.
   always_comb begin
      w_count = CNT_W'(r_remaining);
      if (r_state == IDLE) begin
         w_count = CNT_W'(w_eff_len);
      end
      w_last  = (w_count <= c_word_bytes);
      w_sop   = (r_state == IDLE);
      w_eop   = w_last || w_abort;
      w_empty = '0;
      if (w_last && !w_abort) begin
         w_empty = EMPTY_W'(c_word_bytes - w_count);
      end
   end

   // Packet state and byte counter advance once per accepted input word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_remaining <= '0;
      end else if (w_load) begin
         if (w_eop) begin
            r_state     <= IDLE;
            r_remaining <= '0;
         end else begin
            r_state     <= ACTIVE;
            r_remaining <= LEN_W'(w_count - c_word_bytes);
         end
      end
   end

   // Open-packet flag: set on the sop load, cleared when the eop word is taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= 1'b0;
      end else if (w_load && w_sop) begin
         r_busy <= 1'b1;
      end else if (w_q_valid && bus.out_ready && w_q_eop) begin
         r_busy <= 1'b0;
      end
   end

   assign busy = r_busy;

`ifdef AVALON_PACKETIZER_ABORT_EN
   assign w_pay_d = {w_abort, w_empty, w_eop, w_sop, bus.in_data};
   assign {bus.out_error, bus.out_empty, w_q_eop, bus.out_startofpacket,
           bus.out_data} = w_pay_q;
`else
   assign w_pay_d = {w_empty, w_eop, w_sop, bus.in_data};
   assign {bus.out_empty, w_q_eop, bus.out_startofpacket, bus.out_data} = w_pay_q;
`endif

   assign bus.out_endofpacket = w_q_eop;
   assign bus.out_valid       = w_q_valid;
   assign bus.in_ready        = w_in_ready;

   avalon_st_out_reg #(
      .PAYLOAD_W (PAYLOAD_W)
   ) u_out_reg (
      .clk     (clk),
      .rst     (rst),
      .i_valid (bus.in_valid),
      .o_ready (w_in_ready),
      .i_data  (w_pay_d),
      .o_valid (w_q_valid),
      .o_data  (w_pay_q),
      .i_ready (bus.out_ready)
   );

endmodule
`default_nettype wire

// File: tb/tb_avalon_st_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_st_packetizer
// Description : Directed self-checking bench for avalon_st_packetizer with
//               4-byte words and 64-byte maximum packets. Abort checks are
//               compiled in with AVALON_PACKETIZER_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_st_packetizer;

   localparam int DW   = 4;
   localparam int MAXB = 64;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] cfg;
   logic       busy;
   int         n_vec = 0;
   int         n_err = 0;

   avalon_st_packetizer_if #(.DATA_WIDTH_IN_BYTES(DW)) bus ();

   avalon_st_packetizer #(
      .DATA_WIDTH_IN_BYTES (DW),
      .MAX_PACKET_BYTES    (MAXB)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .cfg_packet_len (cfg),
      .bus            (bus),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compares {valid, sop, eop, empty, data} as one vector.
   task automatic expect_word(input string tag, input logic v, input logic sop,
                              input logic eop, input logic [1:0] emp,
                              input logic [31:0] d);
      chk(tag, {27'd0, bus.out_valid, bus.out_startofpacket, bus.out_endofpacket,
                bus.out_empty, bus.out_data},
               {27'd0, v, sop, eop, emp, d});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] d);
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b1;
      cfg           = 7'd10;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
`ifdef AVALON_PACKETIZER_ABORT_EN
      bus.in_abort  = 1'b0;
`endif
      tick();
      tick();
      expect_word("reset_out", 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
      chk("reset_busy", {63'd0, busy}, 64'd0);
      rst = 1'b0;
      #1;
      chk("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);

      // 10-byte packets: 3 words, last word empty=2; back-to-back next sop
      push(32'hA000_0000);
      expect_word("len10_w0", 1'b1, 1'b1, 1'b0, 2'd0, 32'hA000_0000);
      chk("len10_busy", {63'd0, busy}, 64'd1);
      push(32'hA000_0001);
      expect_word("len10_w1", 1'b1, 1'b0, 1'b0, 2'd0, 32'hA000_0001);
      push(32'hA000_0002);
      expect_word("len10_w2", 1'b1, 1'b0, 1'b1, 2'd2, 32'hA000_0002);
      push(32'hB000_0000);
      expect_word("len10_next_sop", 1'b1, 1'b1, 1'b0, 2'd0, 32'hB000_0000);
      chk("len10_busy_b2b", {63'd0, busy}, 64'd1);
      push(32'hB000_0001);
      push(32'hB000_0002);
      expect_word("len10_b_w2", 1'b1, 1'b0, 1'b1, 2'd2, 32'hB000_0002);
      tick();
      chk("len10_drain_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("len10_drain_busy", {63'd0, busy}, 64'd0);

      // Single-word packets
      cfg = 7'd4;
      push(32'hC000_0004);
      expect_word("len4", 1'b1, 1'b1, 1'b1, 2'd0, 32'hC000_0004);
      chk("len4_busy", {63'd0, busy}, 64'd1);
      tick();
      chk("len4_busy_after", {63'd0, busy}, 64'd0);
      cfg = 7'd3;
      push(32'hC000_0003);
      expect_word("len3", 1'b1, 1'b1, 1'b1, 2'd1, 32'hC000_0003);
      tick();

      // Zero and oversize lengths fall back to 64 bytes = 16 words
      cfg = 7'd0;
      for (int i = 0; i < 16; i++) begin
         push(32'h3000_0000 + i);
         if (i == 0)  expect_word("len0_w0",  1'b1, 1'b1, 1'b0, 2'd0, 32'h3000_0000);
         if (i == 14) expect_word("len0_w14", 1'b1, 1'b0, 1'b0, 2'd0, 32'h3000_000E);
         if (i == 15) expect_word("len0_w15", 1'b1, 1'b0, 1'b1, 2'd0, 32'h3000_000F);
      end
      cfg = 7'd100;
      for (int i = 0; i < 16; i++) begin
         push(32'h4000_0000 + i);
         if (i == 0)  expect_word("len100_w0",  1'b1, 1'b1, 1'b0, 2'd0, 32'h4000_0000);
         if (i == 14) expect_word("len100_w14", 1'b1, 1'b0, 1'b0, 2'd0, 32'h4000_000E);
         if (i == 15) expect_word("len100_w15", 1'b1, 1'b0, 1'b1, 2'd0, 32'h4000_000F);
      end
      tick();

      // 12-byte packet with backpressure and a length change mid-packet
      cfg = 7'd12;
      push(32'hD000_0000);
      expect_word("stall_w0", 1'b1, 1'b1, 1'b0, 2'd0, 32'hD000_0000);
      cfg = 7'd4;
      bus.out_ready = 1'b0;
      bus.in_data   = 32'hD000_0001;
      bus.in_valid  = 1'b1;
      #1;
      chk("stall_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
      tick();
      expect_word("stall_hold_w0", 1'b1, 1'b1, 1'b0, 2'd0, 32'hD000_0000);
      chk("stall_in_ready_low2", {63'd0, bus.in_ready}, 64'd0);
      bus.out_ready = 1'b1;
      #1;
      chk("stall_in_ready_high", {63'd0, bus.in_ready}, 64'd1);
      tick();
      expect_word("stall_w1", 1'b1, 1'b0, 1'b0, 2'd0, 32'hD000_0001);
      bus.in_data   = 32'hD000_0002;
      bus.out_ready = 1'b0;
      tick();
      expect_word("stall_hold_w1a", 1'b1, 1'b0, 1'b0, 2'd0, 32'hD000_0001);
      tick();
      expect_word("stall_hold_w1b", 1'b1, 1'b0, 1'b0, 2'd0, 32'hD000_0001);
      bus.out_ready = 1'b1;
      tick();
      expect_word("stall_w2", 1'b1, 1'b0, 1'b1, 2'd0, 32'hD000_0002);
      bus.in_valid = 1'b0;
      tick();
      chk("stall_drain_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("stall_drain_busy", {63'd0, busy}, 64'd0);
      push(32'hD000_0003);
      expect_word("stall_new_len4", 1'b1, 1'b1, 1'b1, 2'd0, 32'hD000_0003);
      tick();

      // Asynchronous reset mid-packet (8-word packet)
      cfg = 7'd32;
      push(32'hE000_0000);
      push(32'hE000_0001);
      expect_word("rstmid_w1", 1'b1, 1'b0, 1'b0, 2'd0, 32'hE000_0001);
      #2;
      rst = 1'b1;
      #1;
      expect_word("rstmid_out", 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
      chk("rstmid_busy", {63'd0, busy}, 64'd0);
      #2;
      rst = 1'b0;
      push(32'hE100_0000);
      expect_word("rstmid_sop", 1'b1, 1'b1, 1'b0, 2'd0, 32'hE100_0000);
      for (int i = 1; i < 8; i++) begin
         push(32'hE100_0000 + i);
         if (i == 7) expect_word("rstmid_eop", 1'b1, 1'b0, 1'b1, 2'd0, 32'hE100_0007);
      end
      tick();

`ifdef AVALON_PACKETIZER_ABORT_EN
      // Abort on the third word of a 20-byte packet
      cfg = 7'd20;
      push(32'hF000_0000);
      chk("abort_w0_err", {63'd0, bus.out_error}, 64'd0);
      push(32'hF000_0001);
      bus.in_abort = 1'b1;
      push(32'hF000_0002);
      bus.in_abort = 1'b0;
      expect_word("abort_w2", 1'b1, 1'b0, 1'b1, 2'd0, 32'hF000_0002);
      chk("abort_w2_err", {63'd0, bus.out_error}, 64'd1);
      push(32'hF000_0003);
      expect_word("abort_next_sop", 1'b1, 1'b1, 1'b0, 2'd0, 32'hF000_0003);
      chk("abort_next_err", {63'd0, bus.out_error}, 64'd0);
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
